// File: rtl/sonar_echo_timer.sv
// ============================================================================
// Module  : sonar_echo_timer
// Purpose : Periodic ultrasonic ranging: trigger pulse, echo width timing, timeout.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sonar_echo_timer #(
    parameter int unsigned TRIG_CYCLES    = 120,
    parameter int unsigned TIMEOUT_CYCLES = 456000,
    parameter int unsigned PERIOD_CYCLES  = 720000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        echo_in,
    output logic        trig_out,
    output logic [31:0] duration,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    localparam logic [31:0] c_TRIG_LAST   = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] c_TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] c_WIDTH_MAX   = 32'hFFFF_FFFE;
    localparam logic [31:0] c_NO_TARGET   = 32'hFFFF_FFFF;

    logic [2:0]  r_state;
    logic        r_sync1;
    logic        r_echo_s;
    logic        r_echo_d;
    logic [31:0] r_trig_cnt;
    logic [31:0] r_period_cnt;
    logic [31:0] r_tmo_cnt;
    logic [31:0] r_width;
    logic [31:0] r_duration;
    logic        r_valid;
    logic        r_timeout;

    logic        w_rise;
    logic        w_tmo_hit;

    // An echo already high when WAIT_RISE is entered has r_echo_d=1, so it never
    // qualifies as a rising edge.
    assign w_rise    = r_echo_s & ~r_echo_d;
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_echo_s     <= 1'b0;
            r_echo_d     <= 1'b0;
            r_trig_cnt   <= 32'd0;
            r_period_cnt <= 32'd0;
            r_tmo_cnt    <= 32'd0;
            r_width      <= 32'd0;
            r_duration   <= c_NO_TARGET;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_sync1  <= echo_in;
            r_echo_s <= r_sync1;
            r_echo_d <= r_echo_s;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state      <= S_TRIG;
                        r_trig_cnt   <= 32'd0;
                        r_period_cnt <= 32'd0;
                    end
                end

                S_TRIG: begin
                    r_period_cnt <= r_period_cnt + 32'd1;
                    if (r_trig_cnt == c_TRIG_LAST) begin
                        r_state   <= S_WAIT_RISE;
                        r_tmo_cnt <= 32'd0;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + 32'd1;
                    end
                end

                S_WAIT_RISE: begin
                    r_period_cnt <= r_period_cnt + 32'd1;
                    r_tmo_cnt    <= r_tmo_cnt + 32'd1;
                    if (w_tmo_hit) begin
                        r_state    <= S_HOLDOFF;
                        r_duration <= c_NO_TARGET;
                        r_valid    <= 1'b1;
                        r_timeout  <= 1'b1;
                    end else if (w_rise) begin
                        r_state <= S_MEASURE;
                        r_width <= 32'd1;
                    end
                end

                S_MEASURE: begin
                    r_period_cnt <= r_period_cnt + 32'd1;
                    r_tmo_cnt    <= r_tmo_cnt + 32'd1;
                    // Echo fall wins over a coincident timeout.
                    if (!r_echo_s) begin
                        r_state    <= S_HOLDOFF;
                        r_duration <= r_width;
                        r_valid    <= 1'b1;
                    end else if (w_tmo_hit) begin
                        r_state    <= S_HOLDOFF;
                        r_duration <= c_NO_TARGET;
                        r_valid    <= 1'b1;
                        r_timeout  <= 1'b1;
                    end else if (r_width != c_WIDTH_MAX) begin
                        r_width <= r_width + 32'd1;
                    end
                end

                S_HOLDOFF: begin
                    if (r_period_cnt == c_PERIOD_LAST) begin
                        if (en) begin
                            r_state      <= S_TRIG;
                            r_trig_cnt   <= 32'd0;
                            r_period_cnt <= 32'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_period_cnt <= r_period_cnt + 32'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign trig_out = (r_state == S_TRIG);
    assign busy     = (r_state != S_IDLE);
    assign duration = r_duration;
    assign valid    = r_valid;
    assign timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_sonar_echo_timer.sv
// ============================================================================
// Module  : tb_sonar_echo_timer
// Purpose : Directed self-checking bench for sonar_echo_timer (4/100/200 cycles).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sonar_echo_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        echo_in = 1'b0;
    logic        trig_out;
    logic [31:0] duration;
    logic        valid;
    logic        timeout;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int consec = 0;

    sonar_echo_timer #(
        .TRIG_CYCLES   (4),
        .TIMEOUT_CYCLES(100),
        .PERIOD_CYCLES (200)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .echo_in (echo_in),
        .trig_out(trig_out),
        .duration(duration),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic prev_v = 1'b0;
    logic prev_t = 1'b0;
    always @(negedge clk) begin
        if ((valid === 1'b1 && prev_v === 1'b1) || (timeout === 1'b1 && prev_t === 1'b1))
            consec <= consec + 1;
        prev_v <= valid;
        prev_t <= timeout;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int maxc, output logic [31:0] d,
                              output logic t, output int at);
        bit found = 0;
        d = 32'h0; t = 1'b0; at = 0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (valid === 1'b1) begin
                found = 1; d = duration; t = timeout; at = cyc;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_trig(input string tag, output int rc);
        bit found = 0;
        rc = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (trig_out === 1'b1) begin
                found = 1; rc = cyc;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Called on the first tick with trig high; returns on the first tick with it low.
    task automatic count_trig(output int n);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (trig_out !== 1'b1) break;
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        t;
        int at, n, w, r0, r1, r2, r3, r4, nv, nt;

        // Reset state
        repeat (3) tick();
        check("rst_duration", duration, 32'hFFFF_FFFF);
        check("rst_trig", 32'(trig_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        rst = 1'b1; en = 1'b1;
        tick();
        check("first_trig_start", 32'(trig_out), 32'd1);
        r0 = cyc;
        count_trig(n);
        check("trig_width", 32'(n), 32'd4);
        w = cyc;

        // Normal echo of 37 cycles, 10 cycles after trigger falls
        repeat (10) tick();
        echo_in = 1'b1;
        repeat (37) tick();
        echo_in = 1'b0;
        wait_valid("norm_found", 50, d, t, at);
        check("norm_duration", d, 32'd37);
        check("norm_timeout", 32'(t), 32'd0);
        nv = 0; r1 = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (valid === 1'b1) nv++;
            if (trig_out === 1'b1) begin r1 = cyc; break; end
        end
        check("norm_single_valid", 32'(nv), 32'd0);
        check("period_1", 32'(r1 - r0), 32'd200);

        // No echo: timeout 100 cycles after WAIT_RISE entry
        count_trig(n);
        check("trig_width_2", 32'(n), 32'd4);
        w = cyc;
        wait_valid("noecho_found", 150, d, t, at);
        check("noecho_latency", 32'(at - w), 32'd100);
        check("noecho_timeout", 32'(t), 32'd1);
        check("noecho_duration", d, 32'hFFFF_FFFF);
        tick();
        check("noecho_valid_pulse", 32'(valid), 32'd0);
        check("noecho_timeout_pulse", 32'(timeout), 32'd0);

        // Stuck echo rising 5 cycles after trigger start
        wait_trig("stuck_trig", r2);
        check("period_2", 32'(r2 - r1), 32'd200);
        count_trig(n);
        w = cyc;
        tick();
        echo_in = 1'b1;
        wait_valid("stuck_found", 150, d, t, at);
        check("stuck_latency", 32'(at - w), 32'd100);
        check("stuck_timeout", 32'(t), 32'd1);
        check("stuck_duration", d, 32'hFFFF_FFFF);

        // Echo already high before the trigger
        wait_trig("pre_trig", r3);
        check("period_3", 32'(r3 - r2), 32'd200);
        count_trig(n);
        w = cyc;
        wait_valid("pre_found", 150, d, t, at);
        check("pre_timeout", 32'(t), 32'd1);
        check("pre_duration", d, 32'hFFFF_FFFF);
        echo_in = 1'b0;

        // en dropped mid-measurement: result delivered, then idle
        wait_trig("en_trig", r4);
        count_trig(n);
        w = cyc;
        repeat (3) tick();
        echo_in = 1'b1;
        repeat (7) tick();
        en = 1'b0;
        repeat (10) tick();
        echo_in = 1'b0;
        wait_valid("en_found", 50, d, t, at);
        check("en_duration", d, 32'd17);
        check("en_timeout", 32'(t), 32'd0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy === 1'b0) break;
        end
        check("en_busy_low", 32'(busy), 32'd0);
        check("en_idle_time", 32'(cyc - r4), 32'd200);
        nt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (trig_out === 1'b1) nt++;
        end
        check("en_no_trig", 32'(nt), 32'd0);

        // Reset during measurement at width 20
        en = 1'b1;
        tick();
        check("rm_trig_start", 32'(trig_out), 32'd1);
        count_trig(n);
        repeat (2) tick();
        echo_in = 1'b1;
        repeat (22) tick();
        check("rm_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("rm_trig", 32'(trig_out), 32'd0);
        check("rm_valid", 32'(valid), 32'd0);
        check("rm_duration", duration, 32'hFFFF_FFFF);
        check("rm_busy", 32'(busy), 32'd0);
        echo_in = 1'b0;
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid === 1'b1) nv++;
        end
        check("rm_no_valid", 32'(nv), 32'd0);
        rst = 1'b1;
        tick();
        check("rm_retrig_start", 32'(trig_out), 32'd1);
        count_trig(n);
        check("rm_retrig_width", 32'(n), 32'd4);
        check("rm_duration_after", duration, 32'hFFFF_FFFF);

        check("no_consecutive_pulses", 32'(consec), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
